// File: rtl/sar_pkg.sv
// Shared types and constants for the SAR comparator responder.
package sar_pkg;

    localparam int unsigned SarWidth = 6;
    localparam int unsigned CntWidth = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_WAIT_EOC,
        ST_CHECK,
        ST_NEXT,
        ST_DONE
    } state_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CntWidth-1:0] sat_inc(input logic [CntWidth-1:0] value);
        return (&value) ? value : value + CntWidth'(1);
    endfunction

endpackage

// File: rtl/sar_sh_cmp.sv
// Sample-and-hold register plus unsigned comparator against the SAR trial code.
module sar_sh_cmp
    import sar_pkg::*;
#(
    parameter int unsigned Width = SarWidth
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sample,
    input  logic [Width-1:0] source,
    input  logic [Width-1:0] dac,
    output logic [Width-1:0] held,
    output logic             cmp
);

    logic [Width-1:0] held_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            held_reg <= '0;
        end else if (sample) begin
            held_reg <= source;
        end
    end

    // Combinational so the SAR sees the decision in the cycle it drives dac.
    assign cmp  = (held_reg >= dac);
    assign held = held_reg;

endmodule

// File: rtl/sar_cmp_responder.sv
// Sequencer/checker for the SAR loop stand-in; SAR_RESP_TOL_EN accepts a +/-1 LSB result.
module sar_cmp_responder
    import sar_pkg::*;
#(
    parameter int unsigned Width         = SarWidth,
    parameter int unsigned TimeoutCycles = 32
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                run_i,
    input  logic                mode_i,
    input  logic [Width-1:0]    ain_i,
    input  logic                sample_i,
    input  logic [Width-1:0]    dac_i,
    input  logic                eoc_i,
    input  logic [Width-1:0]    result_i,
    output logic                start_o,
    output logic                cmp_o,
    output logic [Width-1:0]    held_o,
    output logic                busy_o,
    output logic                done_o,
    output logic                timeout_o,
    output logic [CntWidth-1:0] err_cnt_o,
    output logic [CntWidth-1:0] conv_cnt_o
);

    localparam int unsigned TW = $clog2(TimeoutCycles + 1);

    state_t              state_reg, state_next;
    logic [Width-1:0]    ramp_reg, ramp_next;
    logic                mode_reg, mode_next;
    logic [TW-1:0]       tcnt_reg, tcnt_next;
    logic                timeout_reg, timeout_next;
    logic [CntWidth-1:0] err_reg, err_next;
    logic [CntWidth-1:0] conv_reg, conv_next;

    logic             mode_eff;
    logic [Width-1:0] source;
    logic [Width-1:0] held;
    logic             match;

    // The hold edge closes the START cycle, so the freshly sampled mode must apply there.
    assign mode_eff = (state_reg == ST_START) ? mode_i : mode_reg;
    assign source   = mode_eff ? ramp_reg : ain_i;

    sar_sh_cmp #(.Width(Width)) u_sh_cmp (
        .clk    (clk_i),
        .rst_n  (rst_ni),
        .sample (sample_i),
        .source (source),
        .dac    (dac_i),
        .held   (held),
        .cmp    (cmp_o)
    );

`ifdef SAR_RESP_TOL_EN
    logic [Width:0] diff;
    assign diff  = (result_i >= held) ? ({1'b0, result_i} - {1'b0, held})
                                      : ({1'b0, held} - {1'b0, result_i});
    assign match = (diff <= (Width+1)'(1));
`else
    assign match = (result_i == held);
`endif

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_reg   <= ST_IDLE;
            ramp_reg    <= '0;
            mode_reg    <= 1'b0;
            tcnt_reg    <= '0;
            timeout_reg <= 1'b0;
            err_reg     <= '0;
            conv_reg    <= '0;
        end else begin
            state_reg   <= state_next;
            ramp_reg    <= ramp_next;
            mode_reg    <= mode_next;
            tcnt_reg    <= tcnt_next;
            timeout_reg <= timeout_next;
            err_reg     <= err_next;
            conv_reg    <= conv_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        ramp_next    = ramp_reg;
        mode_next    = mode_reg;
        tcnt_next    = tcnt_reg;
        timeout_next = timeout_reg;
        err_next     = err_reg;
        conv_next    = conv_reg;
        start_o      = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (run_i) state_next = ST_START;
            end
            ST_START: begin
                start_o    = 1'b1;
                tcnt_next  = '0;
                mode_next  = mode_i;
                state_next = ST_WAIT_EOC;
            end
            ST_WAIT_EOC: begin
                if (eoc_i) begin
                    state_next = ST_CHECK;
                end else if (tcnt_reg == TW'(TimeoutCycles - 1)) begin
                    timeout_next = 1'b1;
                    err_next     = sat_inc(err_reg);
                    state_next   = ST_IDLE;
                end else begin
                    tcnt_next = tcnt_reg + TW'(1);
                end
            end
            ST_CHECK: begin
                if (!match) err_next = sat_inc(err_reg);
                conv_next  = conv_reg + CntWidth'(1);
                state_next = ST_NEXT;
            end
            ST_NEXT: begin
                if (mode_reg) ramp_next = ramp_reg + Width'(1);
                if (mode_reg && (&ramp_reg)) state_next = ST_DONE;
                else if (run_i)              state_next = ST_START;
                else                         state_next = ST_IDLE;
            end
            ST_DONE: begin
                if (!run_i) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign held_o     = held;
    assign busy_o     = (state_reg != ST_IDLE) && (state_reg != ST_DONE);
    assign done_o     = (state_reg == ST_DONE);
    assign timeout_o  = timeout_reg;
    assign err_cnt_o  = err_reg;
    assign conv_cnt_o = conv_reg;

endmodule

// File: tb/tb_sar_cmp_responder.sv
// Self-checking bench: behavioural SAR in the loop, counters checked against a simple model.
module tb_sar_cmp_responder;

    localparam int W = 6;

    logic         clk_i = 1'b0;
    logic         rst_ni;
    logic         run_i;
    logic         mode_i;
    logic [W-1:0] ain_i;
    logic         sample_i;
    logic [W-1:0] dac_i;
    logic         eoc_i;
    logic [W-1:0] result_i;
    logic         start_o;
    logic         cmp_o;
    logic [W-1:0] held_o;
    logic         busy_o;
    logic         done_o;
    logic         timeout_o;
    logic [7:0]   err_cnt_o;
    logic [7:0]   conv_cnt_o;

    int errors = 0;
    int checks = 0;

    // Reference model state
    int exp_err  = 0;
    int exp_conv = 0;
    int exp_ramp = 0;
`ifdef SAR_RESP_TOL_EN
    localparam int TolLsb = 1;
`else
    localparam int TolLsb = 0;
`endif

    sar_cmp_responder #(.Width(W), .TimeoutCycles(32)) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .run_i      (run_i),
        .mode_i     (mode_i),
        .ain_i      (ain_i),
        .sample_i   (sample_i),
        .dac_i      (dac_i),
        .eoc_i      (eoc_i),
        .result_i   (result_i),
        .start_o    (start_o),
        .cmp_o      (cmp_o),
        .held_o     (held_o),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .timeout_o  (timeout_o),
        .err_cnt_o  (err_cnt_o),
        .conv_cnt_o (conv_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int err_after(input int cur, input bit bad);
        if (bad && cur < 255) return cur + 1;
        return cur;
    endfunction

    task automatic wait_start(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 8 && !ok; i++) begin
            @(negedge clk_i);
            if (start_o === 1'b1) ok = 1'b1;
        end
    endtask

    // Entered on the negedge inside the START cycle; returns on the negedge inside CHECK.
    task automatic sar_convert(input int offset, output logic [W-1:0] code);
        logic [W-1:0] trial;
        code = '0;
        @(negedge clk_i);
        check("start_width", {31'd0, start_o}, 32'd0);
        sample_i = 1'b0;
        for (int b = W - 1; b >= 0; b--) begin
            trial = code | (W'(1) << b);
            dac_i = trial;
            #1;
            if (cmp_o) code = trial;
            @(negedge clk_i);
        end
        result_i = W'(int'(code) + offset);
        eoc_i    = 1'b1;
        @(negedge clk_i);
        eoc_i    = 1'b0;
        sample_i = 1'b1;
        $display("conv: code=%02h result=%02h", code, result_i);
    endtask

    // Single conversion from run_i pulse in ain mode, with counter checks afterwards.
    task automatic pulse_conversion(input logic [W-1:0] ain, input int offset, input string tag);
        logic [W-1:0] code;
        int diff;
        ain_i  = ain;
        mode_i = 1'b0;
        run_i  = 1'b1;
        @(negedge clk_i);
        run_i  = 1'b0;
        check({tag, "_start"}, {31'd0, start_o}, 32'd1);
        sar_convert(offset, code);
        check({tag, "_code"}, {26'd0, code}, {26'd0, ain});
        diff = offset < 0 ? -offset : offset;
        exp_err  = err_after(exp_err, diff > TolLsb);
        exp_conv = (exp_conv + 1) % 256;
        @(negedge clk_i);
        check({tag, "_err"}, {24'd0, err_cnt_o}, exp_err);
        check({tag, "_conv"}, {24'd0, conv_cnt_o}, exp_conv);
        @(negedge clk_i);
        check({tag, "_idle"}, {30'd0, busy_o, start_o}, 32'd0);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_start"},   {31'd0, start_o},   32'd0);
        check({tag, "_held"},    {26'd0, held_o},    32'd0);
        check({tag, "_busy"},    {31'd0, busy_o},    32'd0);
        check({tag, "_done"},    {31'd0, done_o},    32'd0);
        check({tag, "_timeout"}, {31'd0, timeout_o}, 32'd0);
        check({tag, "_err"},     {24'd0, err_cnt_o}, 32'd0);
        check({tag, "_conv"},    {24'd0, conv_cnt_o}, 32'd0);
    endtask

    initial begin
        logic [W-1:0] code;
        logic [W-1:0] hv;
        logic [W-1:0] dv;
        bit ok;

        rst_ni = 1'b0; run_i = 1'b0; mode_i = 1'b0; ain_i = '0;
        sample_i = 1'b1; dac_i = '0; eoc_i = 1'b0; result_i = '0;
        repeat (3) @(negedge clk_i);
        check_reset_state("rst");
        check("rst_cmp_eq", {31'd0, cmp_o}, 32'd1);
        dac_i = 6'h03; #1;
        check("rst_cmp_gt", {31'd0, cmp_o}, 32'd0);
        rst_ni = 1'b1;
        @(negedge clk_i);

        // Directed and random single conversions from the external input
        pulse_conversion(6'h2A, 0, "ain2a");
        repeat (4) @(negedge clk_i);
        check("single_pulse", {31'd0, start_o}, 32'd0);
        for (int i = 0; i < 4; i++) pulse_conversion(W'($urandom_range(0, 63)), 0, "ainrnd");
        pulse_conversion(6'h3F, 0, "ain3f");
        pulse_conversion(6'h00, 0, "ain00");

        // Comparator around the held code, directed then random
        ain_i = 6'h20; sample_i = 1'b1;
        @(negedge clk_i);
        sample_i = 1'b0; ain_i = 6'h05;
        @(negedge clk_i);
        check("cmp_held", {26'd0, held_o}, 32'h20);
        dac_i = 6'h1F; #1; check("cmp_1f", {31'd0, cmp_o}, 32'd1);
        dac_i = 6'h20; #1; check("cmp_20", {31'd0, cmp_o}, 32'd1);
        dac_i = 6'h21; #1; check("cmp_21", {31'd0, cmp_o}, 32'd0);
        for (int i = 0; i < 6; i++) begin
            hv = W'($urandom_range(0, 63));
            dv = W'($urandom_range(0, 63));
            ain_i = hv; sample_i = 1'b1;
            @(negedge clk_i);
            sample_i = 1'b0; ain_i = ~hv; dac_i = dv;
            @(negedge clk_i);
            check("hold_rnd", {26'd0, held_o}, {26'd0, hv});
            check("cmp_rnd", {31'd0, cmp_o}, (int'(hv) >= int'(dv)) ? 32'd1 : 32'd0);
        end
        sample_i = 1'b1;
        @(negedge clk_i);

        // Forced result offsets
        pulse_conversion(6'h10, 1, "off_p1");
        pulse_conversion(6'h10, 2, "off_p2");
        pulse_conversion(6'h11, -1, "off_m1");

        // Timeout: eoc_i never asserted
        run_i = 1'b1;
        @(negedge clk_i);
        run_i = 1'b0;
        check("to_start", {31'd0, start_o}, 32'd1);
        for (int k = 1; k <= 32; k++) @(negedge clk_i);
        check("to_before", {30'd0, busy_o, timeout_o}, 32'b10);
        @(negedge clk_i);
        exp_err = err_after(exp_err, 1'b1);
        check("to_flag", {31'd0, timeout_o}, 32'd1);
        check("to_idle", {31'd0, busy_o}, 32'd0);
        check("to_err", {24'd0, err_cnt_o}, exp_err);
        $display("timeout: err=%0d", err_cnt_o);

        // Full ramp sweep with run_i held high
        mode_i = 1'b1; run_i = 1'b1; exp_ramp = 0;
        for (int i = 0; i < 64; i++) begin
            wait_start(ok);
            check("ramp_start", {31'd0, ok}, 32'd1);
            if (!ok) break;
            sar_convert(0, code);
            check("ramp_code", {26'd0, code}, exp_ramp);
            exp_ramp = (exp_ramp + 1) % 64;
            exp_conv = (exp_conv + 1) % 256;
        end
        repeat (2) @(negedge clk_i);
        check("ramp_done", {31'd0, done_o}, 32'd1);
        check("ramp_busy", {31'd0, busy_o}, 32'd0);
        check("ramp_err", {24'd0, err_cnt_o}, exp_err);
        check("ramp_conv", {24'd0, conv_cnt_o}, exp_conv);
        repeat (3) @(negedge clk_i);
        check("done_hold", {30'd0, done_o, start_o}, 32'b10);
        run_i = 1'b0;
        @(negedge clk_i);
        check("done_clear", {30'd0, done_o, busy_o}, 32'b00);

        // Reset in WAIT_EOC during a sweep; sweep must restart at 0
        run_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wait_start(ok);
            check("pre_rst_start", {31'd0, ok}, 32'd1);
            sar_convert(0, code);
            check("pre_rst_code", {26'd0, code}, i);
        end
        wait_start(ok);
        check("pre_rst_start", {31'd0, ok}, 32'd1);
        @(negedge clk_i);
        sample_i = 1'b0;
        rst_ni = 1'b0;
        @(negedge clk_i);
        check_reset_state("midrst");
        rst_ni = 1'b1; sample_i = 1'b1; eoc_i = 1'b0;
        exp_err = 0; exp_conv = 0;
        for (int i = 0; i < 2; i++) begin
            wait_start(ok);
            check("post_rst_start", {31'd0, ok}, 32'd1);
            sar_convert(0, code);
            check("post_rst_code", {26'd0, code}, i);
            exp_conv++;
        end
        run_i = 1'b0;
        repeat (2) @(negedge clk_i);
        check("post_rst_conv", {24'd0, conv_cnt_o}, exp_conv);
        check("post_rst_err", {24'd0, err_cnt_o}, exp_err);
        check("post_rst_to", {31'd0, timeout_o}, 32'd0);
        check("post_rst_idle", {31'd0, busy_o}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
